// File: rtl/serial_borrow_8_bit_subtractor.sv
// serial_borrow_8_bit_subtractor
// Bit-serial subtractor computing {bout,d} = a - b - bin. It processes one bit
// per clock, LSB first, through a single full-subtractor cell and a registered
// borrow. A start/busy/done handshake frames each WIDTH-cycle operation.
// Optional feature macro: SUB_OVF_EN adds the registered signed-overflow
// output ovf.
module serial_borrow_8_bit_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
`ifdef SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] sa_reg, sb_reg;
   logic             br_reg;
   logic [CW-1:0]    cnt_reg;
   // Only the upper WIDTH-1 bits of the working difference need storage.
   // The newest bit is supplied combinationally at completion.
   logic [WIDTH-2:0] wr_reg;

   logic             x_bit, diff_bit, br_next, last_bit;
   logic [WIDTH-1:0] wr_full;

   // Full-subtractor cell on the current LSBs and the running borrow
   assign x_bit    = sa_reg[0] ^ sb_reg[0];
   assign diff_bit = x_bit ^ br_reg;
   assign br_next  = (~sa_reg[0] & sb_reg[0]) | (~x_bit & br_reg);
   assign last_bit = (cnt_reg == LAST);
   // Working register with the new diff bit shifted in at the MSB
   assign wr_full  = {diff_bit, wr_reg};

   assign busy = (state_reg == SHIFT);
   assign done = (state_reg == DONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the last bit, DONE -> IDLE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, bit-serial shifting and result registration at completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_reg  <= '0;
         sb_reg  <= '0;
         br_reg  <= 1'b0;
         cnt_reg <= '0;
         wr_reg  <= '0;
         d       <= '0;
         bout    <= 1'b0;
`ifdef SUB_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  sa_reg  <= a;
                  sb_reg  <= b;
                  br_reg  <= bin;
                  cnt_reg <= '0;
                  wr_reg  <= '0;
               end
            end
            SHIFT: begin
               sa_reg  <= sa_reg >> 1;
               sb_reg  <= sb_reg >> 1;
               br_reg  <= br_next;
               wr_reg  <= wr_full[WIDTH-1:1];
               cnt_reg <= cnt_reg + CW'(1);
               if (last_bit) begin
                  d    <= wr_full;
                  bout <= br_next;
`ifdef SUB_OVF_EN
                  // Borrow into the MSB differs from borrow out of it
                  ovf  <= br_reg ^ br_next;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_borrow_8_bit_subtractor.sv
// Testbench for serial_borrow_8_bit_subtractor. Expected results come from a
// mod-2^9 arithmetic model. They are queued when an operation is issued and
// popped when done is seen.
module tb_serial_borrow_8_bit_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         bin;
   logic         busy, done;
   logic [W-1:0] d;
   logic         bout;
`ifdef SUB_OVF_EN
   logic         ovf;
`endif

   serial_borrow_8_bit_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
`ifdef SUB_OVF_EN
      .ovf   (ovf),
`endif
      .bout  (bout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
      logic [W:0] r;
      int         s;
      exp_t       e;
      r = {1'b0, aa} - {1'b0, bb} - {{W{1'b0}}, bi};
      s = int'($signed(aa)) - int'($signed(bb)) - (bi ? 1 : 0);
      e.d    = r[W-1:0];
      e.bout = r[W];
      e.ovf  = (s < -128) || (s > 127);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until done is high (bounded); reports busy cycles seen on the way
   task automatic wait_done(input string name, output int busy_cycles, output bit ok);
      busy_cycles = 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) busy_cycles++;
         step();
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: done=%0b required 1 within 40 cycles", name, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      step(); step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b required 0", done); end
      total++; if (d !== 8'h00)   begin bad++; $display("FAIL reset_d: got %h required 00", d); end
      total++; if (bout !== 1'b0) begin bad++; $display("FAIL reset_bout: got %0b required 0", bout); end
`ifdef SUB_OVF_EN
      total++; if (ovf !== 1'b0)  begin bad++; $display("FAIL reset_ovf: got %0b required 0", ovf); end
`endif
      rst = 1'b0;
      step();
      $display("reset: busy=%0b done=%0b d=%h bout=%0b", busy, done, d, bout);
   endtask

   task automatic test_basic();
      logic [W-1:0] ta[6] = '{8'h5A, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h7F};
      logic [W-1:0] tb[6] = '{8'h3C, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h80};
      logic         tc[6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
      int   bc;
      bit   ok;
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         a = ta[i]; b = tb[i]; bin = tc[i]; start = 1'b1;
         sb_q.push_back(model(ta[i], tb[i], tc[i]));
         step();
         start = 1'b0;
         wait_done("basic", bc, ok);
         if (sb_q.size() > 0) e = sb_q.pop_front();
         if (ok) begin
            total++; if (bc !== W) begin bad++; $display("FAIL basic_busy_cycles[%0d]: got %0d required %0d", i, bc, W); end
            total++; if (d !== e.d) begin bad++; $display("FAIL basic_d[%0d]: got %h required %h", i, d, e.d); end
            total++; if (bout !== e.bout) begin bad++; $display("FAIL basic_bout[%0d]: got %0b required %0b", i, bout, e.bout); end
`ifdef SUB_OVF_EN
            total++; if (ovf !== e.ovf) begin bad++; $display("FAIL basic_ovf[%0d]: got %0b required %0b", i, ovf, e.ovf); end
`endif
         end
         $display("basic: a=%h b=%h bin=%0b -> d=%h bout=%0b (exp d=%h bout=%0b)", ta[i], tb[i], tc[i], d, bout, e.d, e.bout);
         step();
         total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width[%0d]: got %0b required 0", i, done); end
      end
   endtask

   task automatic test_ignore_start();
      int   bc, extra;
      bit   ok;
      exp_t e;
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      sb_q.push_back(model(8'h10, 8'h01, 1'b0));
      step();
      start = 1'b0;
      step(); step();
      // busy cycle 3: a competing request that must be ignored
      a = 8'hFF; b = 8'h00; start = 1'b1;
      step();
      start = 1'b0;
      wait_done("ignore", bc, ok);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      if (ok) begin
         total++; if (d !== e.d) begin bad++; $display("FAIL ignore_d: got %h required %h", d, e.d); end
         total++; if (bout !== e.bout) begin bad++; $display("FAIL ignore_bout: got %0b required %0b", bout, e.bout); end
      end
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (done || busy) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_activity: got %0d cycles required 0", extra); end
      total++; if (d !== e.d) begin bad++; $display("FAIL ignore_d_hold: got %h required %h", d, e.d); end
      $display("ignore: d=%h bout=%0b extra_activity=%0d", d, bout, extra);
   endtask

   task automatic test_reset_abort();
      int   bc, stray;
      bit   ok;
      exp_t e;
      a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
      sb_q.push_back(model(8'hAA, 8'h55, 1'b0));
      step();
      start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b required 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %0b required 0", done); end
      total++; if (d !== 8'h00)   begin bad++; $display("FAIL abort_d: got %h required 00", d); end
      total++; if (bout !== 1'b0) begin bad++; $display("FAIL abort_bout: got %0b required 0", bout); end
`ifdef SUB_OVF_EN
      total++; if (ovf !== 1'b0)  begin bad++; $display("FAIL abort_ovf: got %0b required 0", ovf); end
`endif
      sb_q.delete();
      step();
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done) stray++;
      end
      total++; if (stray !== 0) begin bad++; $display("FAIL abort_stray_done: got %0d required 0", stray); end
      a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
      sb_q.push_back(model(8'hAA, 8'h55, 1'b0));
      step();
      start = 1'b0;
      wait_done("abort_retry", bc, ok);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      if (ok) begin
         total++; if (d !== e.d) begin bad++; $display("FAIL abort_retry_d: got %h required %h", d, e.d); end
         total++; if (bout !== e.bout) begin bad++; $display("FAIL abort_retry_bout: got %0b required %0b", bout, e.bout); end
      end
      $display("abort: retry d=%h bout=%0b (exp d=%h bout=%0b)", d, bout, e.d, e.bout);
      step();
   endtask

   task automatic test_back_to_back(input int n);
      int   bc, last_cyc, errs_before;
      bit   ok;
      exp_t e;
      logic [W-1:0] ra, rb;
      logic         rc;
      errs_before = bad;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      a = ra; b = rb; bin = rc; start = 1'b1;
      sb_q.push_back(model(ra, rb, rc));
      last_cyc = 0;
      for (int i = 0; i < n; i++) begin
         wait_done("b2b", bc, ok);
         if (!ok) break;
         if (i > 0) begin
            total++;
            if (cyc - last_cyc !== W + 2) begin
               bad++;
               $display("FAIL b2b_period[%0d]: got %0d required %0d", i, cyc - last_cyc, W + 2);
            end
         end
         last_cyc = cyc;
         if (sb_q.size() > 0) e = sb_q.pop_front();
         total++; if (d !== e.d) begin bad++; $display("FAIL b2b_d[%0d]: got %h required %h", i, d, e.d); end
         total++; if (bout !== e.bout) begin bad++; $display("FAIL b2b_bout[%0d]: got %0b required %0b", i, bout, e.bout); end
`ifdef SUB_OVF_EN
         total++; if (ovf !== e.ovf) begin bad++; $display("FAIL b2b_ovf[%0d]: got %0b required %0b", i, ovf, e.ovf); end
`endif
         if (i < n - 1) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            a = ra; b = rb; bin = rc;
            sb_q.push_back(model(ra, rb, rc));
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      $display("back_to_back: %0d operations, new failures=%0d", n, bad - errs_before);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back(2000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
